// File: rtl/ula_fx_pkg.sv
// ---------------------------------------------------------------------------
// ula_fx_pkg
//   Shared constants for the ula_fx datapath and the blocks that feed it.
//   Holds the 5-bit op-code map understood by ula_fx and the default
//   datapath width. The arbiter only needs OP_NOP (idle op driven when no
//   requester is granted); the remaining codes are listed so that
//   requesters and benches can name operations instead of using numbers.
// ---------------------------------------------------------------------------
package ula_fx_pkg;

    // Default datapath width of ula_fx
    localparam int NUBITS_DEFAULT = 32;

    // Op-code field width
    localparam int OP_W = 5;

    // Integer / logic operations
    localparam logic [OP_W-1:0] OP_NOP   = 5'd0;
    localparam logic [OP_W-1:0] OP_MOV   = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD   = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd3;
    localparam logic [OP_W-1:0] OP_MUL   = 5'd4;
    localparam logic [OP_W-1:0] OP_AND   = 5'd5;
    localparam logic [OP_W-1:0] OP_OR    = 5'd6;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd7;
    localparam logic [OP_W-1:0] OP_NOT   = 5'd8;
    localparam logic [OP_W-1:0] OP_SHL   = 5'd9;
    localparam logic [OP_W-1:0] OP_SHR   = 5'd10;
    localparam logic [OP_W-1:0] OP_SRA   = 5'd11;
    localparam logic [OP_W-1:0] OP_ROL   = 5'd12;
    localparam logic [OP_W-1:0] OP_ROR   = 5'd13;
    localparam logic [OP_W-1:0] OP_INC   = 5'd14;
    localparam logic [OP_W-1:0] OP_DEC   = 5'd15;
    localparam logic [OP_W-1:0] OP_NEG   = 5'd16;

    // Comparisons produce 1 or 0 in the result word
    localparam logic [OP_W-1:0] OP_EQU   = 5'd17;
    localparam logic [OP_W-1:0] OP_NEQ   = 5'd18;
    localparam logic [OP_W-1:0] OP_LES   = 5'd19;
    localparam logic [OP_W-1:0] OP_GRE   = 5'd20;
    localparam logic [OP_W-1:0] OP_LEQ   = 5'd21;
    localparam logic [OP_W-1:0] OP_GEQ   = 5'd22;
    localparam logic [OP_W-1:0] OP_ABS   = 5'd23;

    // Float/int conversions; decoded inside ula_fx, passed through untouched
    localparam logic [OP_W-1:0] OP_F2I   = 5'd24;
    localparam logic [OP_W-1:0] OP_I2F   = 5'd25;
    localparam logic [OP_W-1:0] OP_F2IU  = 5'd26;
    localparam logic [OP_W-1:0] OP_I2FU  = 5'd27;

    // Floating-point arithmetic
    localparam logic [OP_W-1:0] OP_FADD  = 5'd28;
    localparam logic [OP_W-1:0] OP_FMUL  = 5'd29;
    localparam logic [OP_W-1:0] OP_FNEGM = 5'd30;

endpackage

// File: rtl/ula_fx_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Starting at the pointer and scanning
//   upward modulo NREQ, selects the first asserted bit of the valid vector.
//
//   Ports
//     i_valid     in   NREQ   candidate requests (already qualified by caller)
//     i_ptr       in   IDW    first position to consider
//     o_grantOh   out  NREQ   one-hot grant, zero when nothing is valid
//     o_grantIdx  out  IDW    encoded grant, zero when nothing is valid
//     o_any       out  1      at least one candidate was valid
// ---------------------------------------------------------------------------
module rr_pick
    import ula_fx_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grantOh,
    output logic [IDW-1:0]  o_grantIdx,
    output logic            o_any
);

    logic [IDW-1:0] w_idx;

    // Walk the NREQ positions in priority order ptr, ptr+1, ... wrapping
    // at NREQ; the first valid one wins and later hits are ignored.
    always_comb begin
        o_grantOh  = '0;
        o_grantIdx = '0;
        o_any      = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_valid[w_idx]) begin
                o_any             = 1'b1;
                o_grantOh[w_idx]  = 1'b1;
                o_grantIdx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/ula_fx_arb.sv
// ---------------------------------------------------------------------------
// ula_fx_arb
//   Shares one combinational ula_fx datapath between NREQ requesters.
//   Round-robin grant, valid/ready handshakes on request and response side,
//   and a single registered result tagged with the owning requester id.
//
//   Ports
//     clk        in   1            clock, all state on rising edge
//     rst        in   1            synchronous active-high reset
//     req_valid  in   NREQ         requester i presents an operation
//     req_ready  out  NREQ         requester i accepted this cycle (one-hot/zero)
//     req_op     in   NREQ*5       op code of requester i at [5*i+:5]
//     req_in1    in   NREQ*NUBITS  operand 1 of requester i
//     req_in2    in   NREQ*NUBITS  operand 2 of requester i
//     alu_op     out  5            to ula_fx.op (NOP when idle)
//     alu_in1    out  NUBITS       to ula_fx.in1
//     alu_in2    out  NUBITS       to ula_fx.in2
//     alu_out    in   NUBITS       from ula_fx.out
//     alu_zero   in   1            from ula_fx.is_zero
//     rsp_valid  out  NREQ         result register owned by requester i
//     rsp_ready  in   NREQ         requester i takes the result
//     rsp_data   out  NUBITS       registered result
//     rsp_zero   out  1            registered is_zero flag
//     rsp_id     out  IDW          owner of the registered result
// ---------------------------------------------------------------------------
module ula_fx_arb
    import ula_fx_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEFAULT,
    parameter int NREQ   = 2,
    parameter int IDW    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OP_W-1:0]   req_op,
    input  logic [NREQ*NUBITS-1:0] req_in1,
    input  logic [NREQ*NUBITS-1:0] req_in2,
    output logic [OP_W-1:0]        alu_op,
    output logic [NUBITS-1:0]      alu_in1,
    output logic [NUBITS-1:0]      alu_in2,
    input  logic [NUBITS-1:0]      alu_out,
    input  logic                   alu_zero,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [NUBITS-1:0]      rsp_data,
    output logic                   rsp_zero,
    output logic [IDW-1:0]         rsp_id
);

    logic [IDW-1:0]    r_ptr;
    logic [NREQ-1:0]   r_rspValid;
    logic [NUBITS-1:0] r_rspData;
    logic              r_rspZero;
    logic [IDW-1:0]    r_rspId;

    logic              w_drain;
    logic              w_canIssue;
    logic [NREQ-1:0]   w_candidates;
    logic [NREQ-1:0]   w_grantOh;
    logic [IDW-1:0]    w_grantIdx;
    logic              w_accept;
    logic [OP_W-1:0]   w_aluOp;
    logic [NUBITS-1:0] w_aluIn1;
    logic [NUBITS-1:0] w_aluIn2;

    // rsp_valid is one-hot on the owner, so masking it with rsp_ready keeps
    // only the owner's ready; a foreign ready cannot drain the register.
    assign w_drain = |(r_rspValid & rsp_ready);

    // The single result buffer can take a new op when empty or when it is
    // being emptied this very cycle. Reset blocks any ready pulse.
    assign w_canIssue   = !rst && ((r_rspValid == '0) || w_drain);
    assign w_candidates = req_valid & {NREQ{w_canIssue}};

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_valid    (w_candidates),
        .i_ptr      (r_ptr),
        .o_grantOh  (w_grantOh),
        .o_grantIdx (w_grantIdx),
        .o_any      (w_accept)
    );

    assign req_ready = w_grantOh;

    // Route the granted requester's fields to the datapath; with no grant
    // the datapath sees a NOP with zero operands so it stays quiet.
    always_comb begin
        w_aluOp  = OP_NOP;
        w_aluIn1 = '0;
        w_aluIn2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grantOh[i]) begin
                w_aluOp  = req_op[OP_W*i +: OP_W];
                w_aluIn1 = req_in1[NUBITS*i +: NUBITS];
                w_aluIn2 = req_in2[NUBITS*i +: NUBITS];
            end
        end
    end

    assign alu_op  = w_aluOp;
    assign alu_in1 = w_aluIn1;
    assign alu_in2 = w_aluIn2;

    // Result register and round-robin pointer. An accept overwrites the
    // buffer (covering the same-cycle drain case); a drain alone only
    // clears valid so the last data/zero/id remain visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_rspValid <= '0;
            r_rspData  <= '0;
            r_rspZero  <= 1'b0;
            r_rspId    <= '0;
        end else if (w_accept) begin
            r_rspValid <= w_grantOh;
            r_rspData  <= alu_out;
            r_rspZero  <= alu_zero;
            r_rspId    <= w_grantIdx;
            if (w_grantIdx == IDW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grantIdx + 1'b1;
            end
        end else if (w_drain) begin
            r_rspValid <= '0;
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign rsp_zero  = r_rspZero;
    assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_ula_fx_arb.sv
// ---------------------------------------------------------------------------
// tb_ula_fx_arb
//   Directed bench for ula_fx_arb with two requesters. A tiny behavioural
//   stand-in for ula_fx (ADD and EQU) closes the datapath loop.
// ---------------------------------------------------------------------------
module tb_ula_fx_arb;

    localparam int NUBITS = 32;
    localparam int NREQ   = 2;
    localparam int IDW    = 1;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*5-1:0]      req_op;
    logic [NREQ*NUBITS-1:0] req_in1;
    logic [NREQ*NUBITS-1:0] req_in2;
    logic [4:0]             alu_op;
    logic [NUBITS-1:0]      alu_in1;
    logic [NUBITS-1:0]      alu_in2;
    logic [NUBITS-1:0]      alu_out;
    logic                   alu_zero;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [NUBITS-1:0]      rsp_data;
    logic                   rsp_zero;
    logic [IDW-1:0]         rsp_id;

    int checks = 0;
    int errors = 0;

    ula_fx_arb #(
        .NUBITS (NUBITS),
        .NREQ   (NREQ),
        .IDW    (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for ula_fx: ADD (2) and EQU (17), everything else yields 0
    always_comb begin
        alu_out = '0;
        case (alu_op)
            5'd2:    alu_out = alu_in1 + alu_in2;
            5'd17:   alu_out = (alu_in1 == alu_in2) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    // Present (or withdraw) requester i's operation
    task automatic applyStimulus(input int i, input logic v, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        req_valid[i]           = v;
        req_op[5*i +: 5]       = op;
        req_in1[NUBITS*i +: NUBITS] = a;
        req_in2[NUBITS*i +: NUBITS] = b;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_in1   = '0;
        req_in2   = '0;
        rsp_ready = '0;

        // ---- reset state, and no ready pulse while reset is held
        tick();
        tick();
        applyStimulus(0, 1'b1, 5'd2, 32'd5, 32'd7);
        #1;
        checkOutput("rst_req_ready", req_ready, 2'b00);
        checkOutput("rst_rsp_valid", rsp_valid, 2'b00);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_rsp_zero", rsp_zero, 1'b0);
        checkOutput("rst_rsp_id", rsp_id, 1'b0);
        checkOutput("rst_alu_op", alu_op, 5'd0);

        // ---- reset mid-op: accept req0 5+7, then reset the next cycle
        rst = 1'b0;
        #1;
        checkOutput("mid_req_ready", req_ready, 2'b01);
        checkOutput("mid_alu_op", alu_op, 5'd2);
        checkOutput("mid_alu_in2", alu_in2, 32'd7);
        tick();
        checkOutput("mid_rsp_valid_pre", rsp_valid, 2'b01);
        applyStimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("mid_rsp_valid", rsp_valid, 2'b00);
        checkOutput("mid_rsp_data", rsp_data, 32'd0);
        rst       = 1'b0;
        rsp_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("mid_no_rsp", rsp_valid, 2'b00);
        end

        // ---- contention: both valid every cycle, pointer restarted at 0
        applyStimulus(0, 1'b1, 5'd2, 32'd1, 32'd2);
        applyStimulus(1, 1'b1, 5'd2, 32'd10, 32'd20);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("cont_req_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            checkOutput("cont_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput("cont_rsp_id", rsp_id, (k % 2 == 0) ? 1'b0 : 1'b1);
            checkOutput("cont_rsp_data", rsp_data, (k % 2 == 0) ? 32'd3 : 32'd30);
        end
        applyStimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        checkOutput("cont_drained", rsp_valid, 2'b00);

        // ---- single requester 5+7 with pointer back at 0
        rsp_ready = 2'b01;
        applyStimulus(0, 1'b1, 5'd2, 32'd5, 32'd7);
        #1;
        checkOutput("single_req_ready", req_ready, 2'b01);
        tick();
        checkOutput("single_rsp_valid", rsp_valid, 2'b01);
        checkOutput("single_rsp_data", rsp_data, 32'd12);
        checkOutput("single_rsp_id", rsp_id, 1'b0);
        applyStimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        checkOutput("single_drain_valid", rsp_valid, 2'b00);
        checkOutput("single_drain_hold", rsp_data, 32'd12);
        checkOutput("idle_alu_op", alu_op, 5'd0);

        // ---- backpressure: req0 result held 3 cycles while req1 waits
        rsp_ready = 2'b00;
        applyStimulus(0, 1'b1, 5'd2, 32'd100, 32'd1);
        #1;
        checkOutput("bp_req0_grant", req_ready, 2'b01);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
        applyStimulus(1, 1'b1, 5'd2, 32'd40, 32'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("bp_req_ready", req_ready, 2'b00);
            tick();
            checkOutput("bp_rsp_data", rsp_data, 32'd101);
            checkOutput("bp_rsp_valid", rsp_valid, 2'b01);
        end
        rsp_ready = 2'b01;
        #1;
        checkOutput("bp_drain_grant", req_ready, 2'b10);
        tick();
        checkOutput("bp_new_valid", rsp_valid, 2'b10);
        checkOutput("bp_new_data", rsp_data, 32'd42);
        checkOutput("bp_new_id", rsp_id, 1'b1);
        applyStimulus(1, 1'b0, 5'd0, 32'd0, 32'd0);

        // ---- foreign ready: req1 owns the result, only req0 says ready
        applyStimulus(0, 1'b1, 5'd2, 32'd1, 32'd1);
        #1;
        checkOutput("foreign_req_ready", req_ready, 2'b00);
        tick();
        checkOutput("foreign_rsp_valid", rsp_valid, 2'b10);
        checkOutput("foreign_rsp_data", rsp_data, 32'd42);
        checkOutput("foreign_rsp_id", rsp_id, 1'b1);
        rsp_ready = 2'b10;
        #1;
        checkOutput("owner_drain_grant", req_ready, 2'b01);
        tick();
        checkOutput("owner_drain_valid", rsp_valid, 2'b01);
        checkOutput("owner_drain_data", rsp_data, 32'd2);
        applyStimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
        rsp_ready = 2'b11;
        tick();

        // ---- zero flag: EQU 3,3 then ADD 3,-3 on requester 1
        applyStimulus(1, 1'b1, 5'd17, 32'd3, 32'd3);
        tick();
        checkOutput("equ_rsp_data", rsp_data, 32'd1);
        checkOutput("equ_rsp_zero", rsp_zero, 1'b0);
        checkOutput("equ_rsp_id", rsp_id, 1'b1);
        applyStimulus(1, 1'b1, 5'd2, 32'd3, 32'hFFFF_FFFD);
        tick();
        checkOutput("zero_rsp_data", rsp_data, 32'd0);
        checkOutput("zero_rsp_zero", rsp_zero, 1'b1);
        checkOutput("zero_rsp_valid", rsp_valid, 2'b10);
        applyStimulus(1, 1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        checkOutput("nop_alu_op", alu_op, 5'd0);
        checkOutput("nop_alu_in1", alu_in1, 32'd0);
        tick();
        checkOutput("final_drain", rsp_valid, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
